ex_stage: RTL and testbench

- Execute stage of the 5-stage pipeline CPU. It consumes the ID/EX pipeline register outputs and produces ALU results, branch/jump redirects and the control fields bound for EX/MEM.
- It contains a sequential multiply/divide unit with HI/LO registers. The unit runs in the background and raises a pipeline stall only when a dependent instruction reaches EX.
- ALU and redirect paths are combinational into EX/MEM. Only the multiply/divide FSM and HI/LO are clocked.

---
 rtl/ex_pkg.sv | 46 ++++
 rtl/muldiv_unit.sv | 98 +++++++++
 rtl/ex_stage.sv | 107 ++++++++++
 tb/tb_ex_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALUOp codes, R-type funct values,
// and the multiply/divide unit's state and operation types.
package ex_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MD_CYCLES = 32;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned ALUOP_W   = 2;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 2'b11;

  localparam logic [FUNCT_W-1:0] FN_SLL   = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_SRL   = 6'h02;
  localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FN_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FN_DIVU  = 6'h1B;
  localparam logic [FUNCT_W-1:0] FN_ADD   = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB   = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND   = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR    = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT   = 6'h2A;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_op_t;

  function automatic logic is_md_funct(input logic [FUNCT_W-1:0] funct);
    return (funct == FN_MULTU) || (funct == FN_DIVU);
  endfunction

  // Instructions that must wait for an in-flight multiply/divide.
  function automatic logic uses_hilo(input logic [FUNCT_W-1:0] funct);
    return (funct == FN_MFHI) || (funct == FN_MFLO) || is_md_funct(funct);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) with HI/LO.
// One step per cycle; HI/LO are only updated on the final step.
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W    = ex_pkg::DATA_W,
  parameter int unsigned MD_CYCLES = ex_pkg::MD_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  md_op_t            op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  md_state_t         state_q;
  md_op_t            op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] acc_hi_q;
  logic [DATA_W-1:0] acc_lo_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  logic [DATA_W-1:0] acc_hi_d;
  logic [DATA_W-1:0] acc_lo_d;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   rem_diff;

  // One iteration: {acc_hi, acc_lo} holds product/remainder:quotient.
  always_comb begin
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : (DATA_W+1)'(0));
    rem_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    if (op_q == MD_MUL) begin
      acc_hi_d = mul_sum[DATA_W:1];
      acc_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
    end else if (!rem_diff[DATA_W]) begin
      acc_hi_d = rem_diff[DATA_W-1:0];
      acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b1};
    end else begin
      acc_hi_d = rem_shift[DATA_W-1:0];
      acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b0};
    end
  end

  // A zero divisor never borrows, so LO fills with ones and HI ends as the dividend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= MD_MUL;
      cnt_q    <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q     <= op_i;
            b_q      <= b_i;
            acc_hi_q <= '0;
            acc_lo_q <= a_i;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MD_CYCLES - 1)) begin
            hi_q    <= acc_hi_d;
            lo_q    <= acc_lo_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == BUSY);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, branch/jump redirect and EX/MEM control,
// plus a background multiply/divide unit that stalls only dependent instructions.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W    = ex_pkg::DATA_W,
  parameter int unsigned MD_CYCLES = ex_pkg::MD_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         wb_in,
  input  logic [2:0]         m_in,
  input  logic               ex_RegDst,
  input  logic [ALUOP_W-1:0] ex_ALUOp,
  input  logic               ex_ALUSrc,
  input  logic [31:0]        pc_in,
  input  logic [4:0]         shamt_in,
  input  logic               BEQ_BNE_in,
  input  logic               jump_in,
  input  logic [DATA_W-1:0]  RD1_in,
  input  logic [DATA_W-1:0]  RD2_in,
  input  logic [DATA_W-1:0]  immed_extend_in,
  input  logic [25:0]        j_in,
  input  logic [4:0]         rt_in,
  input  logic [4:0]         rd_in,
  output logic [1:0]         wb_out,
  output logic [2:0]         m_out,
  output logic [DATA_W-1:0]  alu_result,
  output logic [DATA_W-1:0]  wd_out,
  output logic [4:0]         dst_out,
  output logic               pc_redirect,
  output logic [31:0]        pc_target,
  output logic               stall
);

  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [FUNCT_W-1:0] funct;
  logic               md_start;
  md_op_t             md_op;
  logic               md_busy;
  logic [DATA_W-1:0]  md_hi;
  logic [DATA_W-1:0]  md_lo;
  logic               br_taken;
  logic [31:0]        jump_target;
  logic [31:0]        branch_target;

  assign op_a  = RD1_in;
  assign op_b  = ex_ALUSrc ? immed_extend_in : RD2_in;
  assign funct = immed_extend_in[FUNCT_W-1:0];

  // Only HI/LO readers and new mul/div issues wait on the unit.
  assign stall    = md_busy && (ex_ALUOp == ALUOP_RTYPE) && uses_hilo(funct);
  assign md_start = !stall && (ex_ALUOp == ALUOP_RTYPE) && is_md_funct(funct);
  assign md_op    = (funct == FN_DIVU) ? MD_DIV : MD_MUL;

  muldiv_unit #(
    .DATA_W    (DATA_W),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .op_i    (md_op),
    .a_i     (op_a),
    .b_i     (RD2_in),
    .busy_o  (md_busy),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  always_comb begin
    alu_result = '0;
    case (ex_ALUOp)
      ALUOP_ADD: alu_result = op_a + op_b;
      ALUOP_SUB: alu_result = op_a - op_b;
      ALUOP_OR:  alu_result = op_a | op_b;
      default: begin
        case (funct)
          FN_ADD:  alu_result = op_a + op_b;
          FN_SUB:  alu_result = op_a - op_b;
          FN_AND:  alu_result = op_a & op_b;
          FN_OR:   alu_result = op_a | op_b;
          FN_SLT:  alu_result = DATA_W'($signed(op_a) < $signed(op_b));
          FN_SLL:  alu_result = RD2_in << shamt_in;
          FN_SRL:  alu_result = RD2_in >> shamt_in;
          FN_MFHI: alu_result = md_hi;
          FN_MFLO: alu_result = md_lo;
          default: alu_result = '0;
        endcase
      end
    endcase
  end

  // Jump wins over a branch; a stalled instruction never redirects.
  assign br_taken      = m_in[2] && ((op_a == op_b) ^ BEQ_BNE_in);
  assign jump_target   = {pc_in[31:28], j_in, 2'b00};
  assign branch_target = pc_in + (32'(immed_extend_in) << 2);
  assign pc_target     = jump_in ? jump_target : branch_target;
  assign pc_redirect   = (jump_in || br_taken) && !stall;

  assign wb_out  = stall ? 2'b00 : wb_in;
  assign m_out   = stall ? 3'b000 : m_in;
  assign wd_out  = RD2_in;
  assign dst_out = ex_RegDst ? rd_in : rt_in;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus random vectors checked against
// a cycle-count model of the multiply/divide unit and arithmetic reference.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_in;
  logic [2:0]  m_in;
  logic        ex_RegDst;
  logic [1:0]  ex_ALUOp;
  logic        ex_ALUSrc;
  logic [31:0] pc_in;
  logic [4:0]  shamt_in;
  logic        BEQ_BNE_in;
  logic        jump_in;
  logic [31:0] RD1_in;
  logic [31:0] RD2_in;
  logic [31:0] immed_extend_in;
  logic [25:0] j_in;
  logic [4:0]  rt_in;
  logic [4:0]  rd_in;
  logic [1:0]  wb_out;
  logic [2:0]  m_out;
  logic [31:0] alu_result;
  logic [31:0] wd_out;
  logic [4:0]  dst_out;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        stall;

  int vecs = 0;
  int errs = 0;

  // Reference state: HI/LO, cycles left on the unit, result waiting to land.
  logic [31:0] m_hi, m_lo, pend_hi, pend_lo;
  int          m_busy;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .wb_in           (wb_in),
    .m_in            (m_in),
    .ex_RegDst       (ex_RegDst),
    .ex_ALUOp        (ex_ALUOp),
    .ex_ALUSrc       (ex_ALUSrc),
    .pc_in           (pc_in),
    .shamt_in        (shamt_in),
    .BEQ_BNE_in      (BEQ_BNE_in),
    .jump_in         (jump_in),
    .RD1_in          (RD1_in),
    .RD2_in          (RD2_in),
    .immed_extend_in (immed_extend_in),
    .j_in            (j_in),
    .rt_in           (rt_in),
    .rd_in           (rd_in),
    .wb_out          (wb_out),
    .m_out           (m_out),
    .alu_result      (alu_result),
    .wd_out          (wd_out),
    .dst_out         (dst_out),
    .pc_redirect     (pc_redirect),
    .pc_target       (pc_target),
    .stall           (stall)
  );

  task automatic clear_inputs();
    wb_in = '0; m_in = '0; ex_RegDst = 1'b0; ex_ALUOp = '0; ex_ALUSrc = 1'b0;
    pc_in = '0; shamt_in = '0; BEQ_BNE_in = 1'b0; jump_in = 1'b0;
    RD1_in = '0; RD2_in = '0; immed_extend_in = '0; j_in = '0; rt_in = '0; rd_in = '0;
  endtask

  // Advance one clock, updating the reference; returns on the falling edge.
  task automatic tick();
    logic        issue;
    logic [5:0]  fn;
    logic [63:0] prod;
    fn    = immed_extend_in[5:0];
    issue = (m_busy == 0) && (ex_ALUOp == 2'b10) && (fn == 6'h19 || fn == 6'h1B);
    @(posedge clk);
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_hi = pend_hi;
        m_lo = pend_lo;
      end
    end
    if (issue) begin
      if (fn == 6'h19) begin
        prod    = {32'd0, RD1_in} * {32'd0, RD2_in};
        pend_hi = prod[63:32];
        pend_lo = prod[31:0];
      end else if (RD2_in == 32'd0) begin
        pend_hi = RD1_in;
        pend_lo = 32'hFFFF_FFFF;
      end else begin
        pend_hi = RD1_in % RD2_in;
        pend_lo = RD1_in / RD2_in;
      end
      m_busy = 32;
    end
    @(negedge clk);
  endtask

  task automatic issue_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    ex_ALUOp = 2'b10; ex_ALUSrc = 1'b0; wb_in = 2'b00; m_in = 3'b000;
    immed_extend_in = {26'd0, fn}; RD1_in = a; RD2_in = b;
    tick();
  endtask

  // Hold a HI/LO reader in EX until it is released; reports stall length and bubbles.
  task automatic wait_md(input logic [5:0] fn, output int stalls, output int leaks);
    ex_ALUOp = 2'b10; immed_extend_in = {26'd0, fn}; wb_in = 2'b11; m_in = 3'b011;
    stalls = 0; leaks = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall !== 1'b1) break;
      stalls++;
      if (wb_out !== 2'b00 || m_out !== 3'b000 || pc_redirect !== 1'b0) leaks++;
      tick();
    end
  endtask

  function automatic logic [31:0] exp_result();
    logic [31:0] b;
    b = ex_ALUSrc ? immed_extend_in : RD2_in;
    case (ex_ALUOp)
      2'b00: return RD1_in + b;
      2'b01: return RD1_in - b;
      2'b11: return RD1_in | b;
      default: begin
        case (immed_extend_in[5:0])
          6'h20:   return RD1_in + b;
          6'h22:   return RD1_in - b;
          6'h24:   return RD1_in & b;
          6'h25:   return RD1_in | b;
          6'h2A:   return ($signed(RD1_in) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00:   return RD2_in << shamt_in;
          6'h02:   return RD2_in >> shamt_in;
          6'h10:   return m_hi;
          6'h12:   return m_lo;
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  function automatic logic exp_stall();
    logic [5:0] fn;
    fn = immed_extend_in[5:0];
    return (m_busy > 0) && (ex_ALUOp == 2'b10) &&
           (fn == 6'h10 || fn == 6'h12 || fn == 6'h19 || fn == 6'h1B);
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1; m_busy = 0; m_hi = '0; m_lo = '0; pend_hi = '0; pend_lo = '0;
    #1;
    vecs++; if (alu_result !== 32'd0) begin errs++; $display("FAIL reset alu_result got %h exp 0", alu_result); end
    vecs++; if (pc_target !== 32'd0) begin errs++; $display("FAIL reset pc_target got %h exp 0", pc_target); end
    vecs++; if (pc_redirect !== 1'b0) begin errs++; $display("FAIL reset pc_redirect got %b exp 0", pc_redirect); end
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL reset stall got %b exp 0", stall); end
    vecs++; if ({wb_out, m_out, dst_out} !== 10'd0) begin errs++; $display("FAIL reset ctrl got %b exp 0", {wb_out, m_out, dst_out}); end
    vecs++; if (wd_out !== 32'd0) begin errs++; $display("FAIL reset wd_out got %h exp 0", wd_out); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    clear_inputs();
    ex_ALUOp = 2'b10; immed_extend_in = 32'h20; RD1_in = 32'd5; RD2_in = 32'd7;
    ex_RegDst = 1'b1; rd_in = 5'd3; rt_in = 5'd9; wb_in = 2'b10;
    #1;
    vecs++; if (alu_result !== 32'd12) begin errs++; $display("FAIL add alu_result got %0d exp 12", alu_result); end
    vecs++; if (dst_out !== 5'd3) begin errs++; $display("FAIL add dst_out got %0d exp 3", dst_out); end
    vecs++; if (stall !== 1'b0 || wb_out !== 2'b10) begin errs++; $display("FAIL add stall/wb got %b/%b exp 0/10", stall, wb_out); end
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    m_in = 3'b100; RD1_in = 32'd9; RD2_in = 32'd9; pc_in = 32'h100; immed_extend_in = 32'd4;
    #1;
    vecs++; if (pc_redirect !== 1'b1) begin errs++; $display("FAIL beq redirect got %b exp 1", pc_redirect); end
    vecs++; if (pc_target !== 32'h110) begin errs++; $display("FAIL beq target got %h exp 00000110", pc_target); end
    BEQ_BNE_in = 1'b1;
    #1;
    vecs++; if (pc_redirect !== 1'b0) begin errs++; $display("FAIL bne_equal redirect got %b exp 0", pc_redirect); end
    RD2_in = 32'd8;
    #1;
    vecs++; if (pc_redirect !== 1'b1) begin errs++; $display("FAIL bne_differ redirect got %b exp 1", pc_redirect); end
    tick();
  endtask

  task automatic test_jump();
    clear_inputs();
    jump_in = 1'b1; pc_in = 32'h4000_0004; j_in = 26'h10;
    m_in = 3'b100; RD1_in = 32'd1; RD2_in = 32'd1; immed_extend_in = 32'd8;
    #1;
    vecs++; if (pc_target !== 32'h4000_0040) begin errs++; $display("FAIL jump target got %h exp 40000040", pc_target); end
    vecs++; if (pc_redirect !== 1'b1) begin errs++; $display("FAIL jump redirect got %b exp 1", pc_redirect); end
    tick();
  endtask

  task automatic test_multu();
    int stalls, leaks;
    clear_inputs();
    issue_md(6'h19, 32'hFFFF_FFFF, 32'd2);
    wait_md(6'h12, stalls, leaks);
    vecs++; if (stalls != 32) begin errs++; $display("FAIL multu stall_cycles got %0d exp 32", stalls); end
    vecs++; if (leaks != 0) begin errs++; $display("FAIL multu bubble got %0d leaking cycles exp 0", leaks); end
    vecs++; if (alu_result !== 32'hFFFF_FFFE) begin errs++; $display("FAIL multu mflo got %h exp fffffffe", alu_result); end
    vecs++; if (wb_out !== 2'b11) begin errs++; $display("FAIL multu released wb got %b exp 11", wb_out); end
    tick();
    immed_extend_in = 32'h10;
    #1;
    vecs++; if (alu_result !== 32'd1) begin errs++; $display("FAIL multu mfhi got %h exp 1", alu_result); end
    tick();
  endtask

  task automatic test_divu();
    int stalls, leaks;
    clear_inputs();
    issue_md(6'h1B, 32'd100, 32'd7);
    wait_md(6'h12, stalls, leaks);
    vecs++; if (stalls != 32) begin errs++; $display("FAIL divu stall_cycles got %0d exp 32", stalls); end
    vecs++; if (alu_result !== 32'd14) begin errs++; $display("FAIL divu mflo got %0d exp 14", alu_result); end
    tick();
    immed_extend_in = 32'h10;
    #1;
    vecs++; if (alu_result !== 32'd2) begin errs++; $display("FAIL divu mfhi got %0d exp 2", alu_result); end
    tick();
    issue_md(6'h1B, 32'd5, 32'd0);
    wait_md(6'h12, stalls, leaks);
    vecs++; if (stalls != 32) begin errs++; $display("FAIL div0 stall_cycles got %0d exp 32", stalls); end
    vecs++; if (alu_result !== 32'hFFFF_FFFF) begin errs++; $display("FAIL div0 mflo got %h exp ffffffff", alu_result); end
    tick();
    immed_extend_in = 32'h10;
    #1;
    vecs++; if (alu_result !== 32'd5) begin errs++; $display("FAIL div0 mfhi got %0d exp 5", alu_result); end
    tick();
  endtask

  task automatic test_back_to_back();
    int stalls, leaks, bad;
    clear_inputs();
    ex_ALUOp = 2'b10; immed_extend_in = 32'h19; RD1_in = 32'd7; RD2_in = 32'd6;
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL b2b issue stall got %b exp 0", stall); end
    tick();
    bad = 0;
    for (int c = 0; c < 32; c++) begin
      ex_ALUOp = 2'b00; RD1_in = $urandom; RD2_in = $urandom;
      #1;
      if (stall !== 1'b0 || alu_result !== RD1_in + RD2_in) bad++;
      tick();
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL b2b independent got %0d bad cycles exp 0", bad); end
    ex_ALUOp = 2'b10; immed_extend_in = 32'h12;
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL b2b finish_edge stall got %b exp 0", stall); end
    vecs++; if (alu_result !== 32'd42) begin errs++; $display("FAIL b2b finish_edge mflo got %0d exp 42", alu_result); end
    tick();
    immed_extend_in = 32'h1B; RD1_in = 32'd100; RD2_in = 32'd10;
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL b2b reissue stall got %b exp 0", stall); end
    tick();
    wait_md(6'h12, stalls, leaks);
    vecs++; if (stalls != 32 || alu_result !== 32'd10) begin
      errs++; $display("FAIL b2b reissue got stalls=%0d lo=%0d exp 32/10", stalls, alu_result);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    issue_md(6'h19, 32'd3, 32'd5);
    immed_extend_in = 32'h12;
    repeat (9) tick();
    #1;
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL rstmid pre stall got %b exp 1", stall); end
    #1;
    rst = 1'b1; m_busy = 0; m_hi = '0; m_lo = '0;
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL rstmid stall got %b exp 0", stall); end
    vecs++; if (alu_result !== 32'd0) begin errs++; $display("FAIL rstmid mflo got %h exp 0", alu_result); end
    rst = 1'b0;
    repeat (36) tick();
    #1;
    vecs++; if (stall !== 1'b0 || alu_result !== 32'd0) begin
      errs++; $display("FAIL rstmid late mflo got stall=%b lo=%h exp 0/0", stall, alu_result);
    end
    immed_extend_in = 32'h10;
    #1;
    vecs++; if (alu_result !== 32'd0) begin errs++; $display("FAIL rstmid mfhi got %h exp 0", alu_result); end
    tick();
  endtask

  task automatic test_random();
    logic [5:0]  fns [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h10, 6'h12, 6'h19, 6'h1B};
    logic [31:0] e_res, e_tgt, b;
    logic        e_st, e_br, e_rd;
    int          k;
    for (int n = 0; n < 400; n++) begin
      wb_in = 2'($urandom); m_in = 3'($urandom); ex_RegDst = 1'($urandom);
      ex_ALUOp = 2'($urandom); ex_ALUSrc = 1'($urandom); pc_in = $urandom;
      shamt_in = 5'($urandom); BEQ_BNE_in = 1'($urandom); jump_in = ($urandom_range(0, 7) == 0);
      RD1_in = $urandom; RD2_in = ($urandom_range(0, 3) == 0) ? RD1_in : $urandom;
      if ($urandom_range(0, 3) == 0) RD2_in = 32'($urandom_range(0, 9));
      j_in = 26'($urandom); rt_in = 5'($urandom); rd_in = 5'($urandom);
      k = $urandom_range(0, 15);
      immed_extend_in = $urandom;
      if (k < 11) immed_extend_in[5:0] = fns[k];
      if (ex_ALUSrc && ($urandom_range(0, 3) == 0)) immed_extend_in = RD1_in;
      #1;
      e_res = exp_result();
      e_st  = exp_stall();
      b     = ex_ALUSrc ? immed_extend_in : RD2_in;
      e_br  = m_in[2] && ((RD1_in == b) != BEQ_BNE_in);
      e_rd  = (jump_in || e_br) && !e_st;
      e_tgt = jump_in ? {pc_in[31:28], j_in, 2'b00} : pc_in + (immed_extend_in << 2);
      vecs++; if (stall !== e_st) begin errs++; $display("FAIL rnd[%0d] stall got %b exp %b", n, stall, e_st); end
      vecs++; if (alu_result !== e_res) begin errs++; $display("FAIL rnd[%0d] alu_result got %h exp %h", n, alu_result, e_res); end
      vecs++; if (pc_redirect !== e_rd) begin errs++; $display("FAIL rnd[%0d] pc_redirect got %b exp %b", n, pc_redirect, e_rd); end
      vecs++; if (pc_target !== e_tgt) begin errs++; $display("FAIL rnd[%0d] pc_target got %h exp %h", n, pc_target, e_tgt); end
      vecs++; if (wb_out !== (e_st ? 2'b00 : wb_in)) begin errs++; $display("FAIL rnd[%0d] wb_out got %b exp %b", n, wb_out, e_st ? 2'b00 : wb_in); end
      vecs++; if (m_out !== (e_st ? 3'b000 : m_in)) begin errs++; $display("FAIL rnd[%0d] m_out got %b exp %b", n, m_out, e_st ? 3'b000 : m_in); end
      vecs++; if (dst_out !== (ex_RegDst ? rd_in : rt_in)) begin errs++; $display("FAIL rnd[%0d] dst_out got %0d exp %0d", n, dst_out, ex_RegDst ? rd_in : rt_in); end
      vecs++; if (wd_out !== RD2_in) begin errs++; $display("FAIL rnd[%0d] wd_out got %h exp %h", n, wd_out, RD2_in); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_jump();
    test_multu();
    test_divu();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
